// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, ack.
// Define PS2_TX_GLITCH_FILTER_EN to add an 8-sample stability filter on the synchronized clock.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_chipset,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       ack_ok,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_lvl, clk_prev, fe;
    logic [7:0]    byte_q;
    logic          parity;
    logic [3:0]    n;
    logic          drive;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          active, timeout_hit, accept;

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [7:0] clk_hist;
    logic       clk_filt;

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            clk_hist <= '1;
            clk_filt <= 1'b1;
        end else begin
            clk_hist <= {clk_hist[6:0], clk_s2};
            if (clk_hist == '1)
                clk_filt <= 1'b1;
            else if (clk_hist == '0)
                clk_filt <= 1'b0;
        end
    end

    assign clk_lvl = clk_filt;
`else
    assign clk_lvl = clk_s2;
`endif

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n)
            clk_prev <= 1'b1;
        else
            clk_prev <= clk_lvl;
    end

    assign fe          = clk_prev & ~clk_lvl;
    assign active      = (state != IDLE) && (state != DONE);
    assign timeout_hit = active && (to_cnt == TO_LAST);
    assign accept      = tx_valid && (state == IDLE);

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        tx_done     = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid)
                    state_nx = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == INH_LAST)
                    state_nx = REQ;
            end
            REQ: begin
                ps2_data_oe = 1'b1;
                if (fe)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                ps2_data_oe = drive;
                if (fe && n == 4'd10)
                    state_nx = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_s2)
                    state_nx = DONE;
            end
            DONE: begin
                tx_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Timeout overrides any edge seen in the same cycle.
        if (timeout_hit)
            state_nx = IDLE;
    end

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            byte_q   <= '0;
            parity   <= 1'b0;
            n        <= '0;
            drive    <= 1'b0;
            ack_ok   <= 1'b0;
            tx_error <= 1'b0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            tx_error <= timeout_hit;
            if (active)
                to_cnt <= to_cnt + TW'(1);
            if (state == INHIBIT)
                inh_cnt <= inh_cnt + IW'(1);
            if (accept) begin
                byte_q  <= tx_data;
                parity  <= ~^tx_data;
                to_cnt  <= '0;
                inh_cnt <= '0;
                ack_ok  <= 1'b0;
            end
            // n holds the index of the edge just acted on; the next edge drives bit n.
            if (fe && !timeout_hit) begin
                if (state == REQ) begin
                    n     <= 4'd1;
                    drive <= ~byte_q[0];
                end else if (state == SHIFT) begin
                    n <= n + 4'd1;
                    if (n <= 4'd7)
                        drive <= ~byte_q[n[2:0]];
                    else if (n == 4'd8)
                        drive <= ~parity;
                    else if (n == 4'd9)
                        drive <= 1'b0;
                    else if (n == 4'd10)
                        ack_ok <= ~data_s2;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on the wired-AND lines.
module tb_ps2_host_tx;
    localparam int INH    = 20;
    localparam int TO     = 2000;
    localparam int LOW    = 20;
    localparam int HIGH   = 20;
    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;

    typedef struct {
        logic [10:0] bits;
        logic        ack;
        logic        timeout;
        int          acc;
    } exp_t;

    logic       clk_chipset = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, ack_ok, tx_error, busy;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;
    logic [10:0] cap;
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;

    always #5 clk_chipset = ~clk_chipset;
    always @(posedge clk_chipset) cyc <= cyc + 1;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_chipset(clk_chipset), .reset_n(reset_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .ack_ok(ack_ok), .tx_error(tx_error), .busy(busy),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Line order: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2 == 0);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic device_frame(input int mode, input int rst_at);
        int g = 0;
        while (!(ps2_clk_in && !ps2_data_in) && g < 300) begin
            @(negedge clk_chipset);
            g++;
        end
        if (g >= 300) begin
            check("request_seen", 32'(g), 32'd0);
            return;
        end
        cap    = '1;
        cap[0] = ps2_data_in;
        if (mode == M_SILENT) begin
            g = 0;
            while (!ps2_data_in && g < TO + 100) begin
                @(negedge clk_chipset);
                g++;
            end
            if (g >= TO + 100) check("silent_release", 32'(ps2_data_in), 32'd1);
            return;
        end
        repeat (30) @(negedge clk_chipset);
`ifdef PS2_TX_GLITCH_FILTER_EN
        dev_clk = 1'b0;
        repeat (3) @(negedge clk_chipset);
        dev_clk = 1'b1;
        repeat (30) @(negedge clk_chipset);
`endif
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (LOW) @(negedge clk_chipset);
            if (k <= 10) cap[k] = ps2_data_in;
            if (k == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_async_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                check("rst_ready", 32'(tx_ready), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                exp_q.delete();
                @(negedge clk_chipset);
                reset_n = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
            repeat (HIGH / 2) @(negedge clk_chipset);
            if (k == 10 && mode == M_ACK) dev_data = 1'b0;
            repeat (HIGH / 2) @(negedge clk_chipset);
        end
    endtask

    task automatic send(input logic [7:0] d, input int mode, input int rst_at);
        exp_t e;
        int   cnt = 0;
        int   g = 0;
        @(negedge clk_chipset);
        check("ready_before_send", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_chipset);
        e.bits    = frame_of(d);
        e.ack     = (mode == M_ACK);
        e.timeout = (mode == M_SILENT);
        e.acc     = cyc;
        exp_q.push_back(e);
        tx_valid = 1'b0;
        tx_data  = (d == 8'h07) ? 8'h55 : 8'($urandom);
        while (ps2_clk_oe && cnt < INH + 50) begin
            cnt++;
            if (cnt == 3) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            if (cnt == 4) tx_valid = 1'b0;
            @(negedge clk_chipset);
        end
        check("inhibit_len", 32'(cnt), 32'(INH));
        check("start_bit_oe", 32'(ps2_data_oe), 32'd1);
        device_frame(mode, rst_at);
        if (rst_at != 0) return;
        while (!tx_ready && g < 300) begin
            @(negedge clk_chipset);
            g++;
        end
        if (g >= 300) check("ready_after_frame", 32'(tx_ready), 32'd1);
        check("ack_hold", 32'(ack_ok), 32'(e.ack));
        cnt = 0;
        repeat (20) begin
            @(negedge clk_chipset);
            if (busy) cnt++;
        end
        check("no_second_frame", 32'(cnt), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_chipset);
            if (tx_done || tx_error) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: actual done=%0b error=%0b expected none", tx_done, tx_error);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_done) begin
                        check("done_kind", 32'(e.timeout), 32'd0);
                        check("frame_bits", 32'(cap), 32'(e.bits));
                        check("ack_ok", 32'(ack_ok), 32'(e.ack));
                        check("no_error_with_done", 32'(tx_error), 32'd0);
                    end else begin
                        check("error_kind", 32'(e.timeout), 32'd1);
                        check("timeout_latency", 32'(cyc - e.acc), 32'(TO));
                        check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                        check("timeout_ready", 32'(tx_ready), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cap      = '1;
        repeat (3) @(negedge clk_chipset);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_done", 32'(tx_done), 32'd0);
        check("reset_error", 32'(tx_error), 32'd0);
        check("reset_ack", 32'(ack_ok), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_chipset);

        send(8'hED, M_ACK, 0);
        send(8'h07, M_ACK, 0);
        send(8'($urandom), M_SILENT, 0);
        send(8'($urandom), M_NACK, 0);
        send(8'($urandom) & 8'hEF, M_ACK, 5);
        repeat (5) @(negedge clk_chipset);
        send(8'hFF, M_ACK, 0);
        for (int i = 0; i < 8; i++)
            send(8'($urandom), int'($urandom_range(0, 1)), 0);

        repeat (10) @(negedge clk_chipset);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
